ebr_dual_buffer: RTL and testbench

Parametrised true dual-port page buffer for the flash controller datapath, succeeding the fixed 8-bit × 2048 EBR buffer. Both ports can read and write, and each port has an auto-incrementing address pointer for streaming page data to and from the flash interface. Same-address collisions are detected and resolved deterministically. An optional output register stage adds one cycle of read latency. Sits between the host-side page interface (port A) and the flash NAND sequencer (port B) in a single clock domain.

---
 rtl/ebr_dual_buffer.sv | 136 +++++++++++++
 tb/tb_ebr_dual_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ebr_dual_buffer.sv
// True dual-port page buffer with per-port auto-incrementing pointers and deterministic
// same-address collision handling. Define EBR_OUT_REG_EN for an extra output register on Q/Valid.
module ebr_dual_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataInA,
    input  logic [DATA_W-1:0] DataInB,
    input  logic [ADDR_W-1:0] AddressA,
    input  logic [ADDR_W-1:0] AddressB,
    input  logic              ClockEnA,
    input  logic              ClockEnB,
    input  logic              WrA,
    input  logic              WrB,
    input  logic              LoadA,
    input  logic              LoadB,
    input  logic              IncA,
    input  logic              IncB,
    output logic [DATA_W-1:0] QA,
    output logic [DATA_W-1:0] QB,
    output logic              ValidA,
    output logic              ValidB,
    output logic              WrapA,
    output logic              WrapB,
    output logic              Collision
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];

    // Index 0 is port A (host side), index 1 is port B (NAND sequencer).
    logic [DATA_W-1:0] din   [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [ADDR_W-1:0] eff   [2];
    logic [DATA_W-1:0] q_out [2];
    logic [1:0]        ce;
    logic [1:0]        wr;
    logic [1:0]        load;
    logic [1:0]        inc;
    logic [1:0]        valid_out;
    logic [1:0]        wrap_out;
    logic              collision_reg;

    assign din[0]  = DataInA;
    assign din[1]  = DataInB;
    assign addr[0] = AddressA;
    assign addr[1] = AddressB;
    assign ce      = {ClockEnB, ClockEnA};
    assign wr      = {WrB, WrA};
    assign load    = {LoadB, LoadA};
    assign inc     = {IncB, IncA};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [ADDR_W-1:0] ptr_reg;
            logic [DATA_W-1:0] q_reg;
            logic              valid_reg;
            logic              wrap_reg;

            assign eff[gi] = load[gi] ? addr[gi] : ptr_reg;

            // Nonblocking read of mem gives read-before-write against either port.
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    ptr_reg   <= '0;
                    q_reg     <= '0;
                    valid_reg <= 1'b0;
                    wrap_reg  <= 1'b0;
                end else begin
                    valid_reg <= ce[gi] && !wr[gi];
                    wrap_reg  <= ce[gi] && inc[gi] && (eff[gi] == '1);
                    if (ce[gi]) begin
                        q_reg <= wr[gi] ? din[gi] : mem[eff[gi]];
                        if (inc[gi])
                            ptr_reg <= eff[gi] + ADDR_ONE;
                        else if (load[gi])
                            ptr_reg <= eff[gi];
                    end
                end
            end

`ifdef EBR_OUT_REG_EN
            logic [DATA_W-1:0] q_pipe_reg;
            logic              valid_pipe_reg;

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    q_pipe_reg     <= '0;
                    valid_pipe_reg <= 1'b0;
                end else begin
                    q_pipe_reg     <= q_reg;
                    valid_pipe_reg <= valid_reg;
                end
            end

            assign q_out[gi]     = q_pipe_reg;
            assign valid_out[gi] = valid_pipe_reg;
`else
            assign q_out[gi]     = q_reg;
            assign valid_out[gi] = valid_reg;
`endif
            assign wrap_out[gi] = wrap_reg;
        end
    endgenerate

    // Port B is written first so a same-address port A write overrides it.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (ce[1] && wr[1])
                mem[eff[1]] <= din[1];
            if (ce[0] && wr[0])
                mem[eff[0]] <= din[0];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            collision_reg <= 1'b0;
        else
            collision_reg <= ce[0] && ce[1] && (eff[0] == eff[1]) && (wr[0] || wr[1]);
    end

    assign QA        = q_out[0];
    assign QB        = q_out[1];
    assign ValidA    = valid_out[0];
    assign ValidB    = valid_out[1];
    assign WrapA     = wrap_out[0];
    assign WrapB     = wrap_out[1];
    assign Collision = collision_reg;

endmodule

// File: tb/tb_ebr_dual_buffer.sv
// Self-checking bench for ebr_dual_buffer: vector table plus hand-written reset sequence,
// with expected outputs queued per edge and compared when the DUT presents them.
module tb_ebr_dual_buffer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 11;
`ifdef EBR_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic              rst;
        logic              ce_a, wr_a, ld_a, inc_a;
        logic [ADDR_W-1:0] ad_a;
        logic [DATA_W-1:0] d_a;
        logic              ce_b, wr_b, ld_b, inc_b;
        logic [ADDR_W-1:0] ad_b;
        logic [DATA_W-1:0] d_b;
        logic              ck_qa;
        logic [DATA_W-1:0] qa;
        logic              va;
        logic              ck_qb;
        logic [DATA_W-1:0] qb;
        logic              vb;
        logic              wa, wb, col;
    } vec_t;

    typedef struct {
        int                due;
        string             tag;
        logic              ck_qa;
        logic [DATA_W-1:0] qa;
        logic              va;
        logic              ck_qb;
        logic [DATA_W-1:0] qb;
        logic              vb;
    } data_exp_t;

    typedef struct {
        int    due;
        string tag;
        logic  wa, wb, col;
    } flag_exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] din_a = '0, din_b = '0;
    logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
    logic              ce_a = 1'b0, ce_b = 1'b0, wr_a = 1'b0, wr_b = 1'b0;
    logic              ld_a = 1'b0, ld_b = 1'b0, inc_a = 1'b0, inc_b = 1'b0;
    logic [DATA_W-1:0] q_a, q_b;
    logic              valid_a, valid_b, wrap_a, wrap_b, collision;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;

    vec_t      vecs[$];
    data_exp_t dq[$];
    flag_exp_t fq[$];

    ebr_dual_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clock(clk), .Reset(rst),
        .DataInA(din_a), .DataInB(din_b),
        .AddressA(addr_a), .AddressB(addr_b),
        .ClockEnA(ce_a), .ClockEnB(ce_b),
        .WrA(wr_a), .WrB(wr_b),
        .LoadA(ld_a), .LoadB(ld_b),
        .IncA(inc_a), .IncB(inc_b),
        .QA(q_a), .QB(q_b),
        .ValidA(valid_a), .ValidB(valid_b),
        .WrapA(wrap_a), .WrapB(wrap_b),
        .Collision(collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic vec_t v_idle();
        vec_t v;
        v.rst = 0; v.ce_a = 0; v.wr_a = 0; v.ld_a = 0; v.inc_a = 0; v.ad_a = '0; v.d_a = '0;
        v.ce_b = 0; v.wr_b = 0; v.ld_b = 0; v.inc_b = 0; v.ad_b = '0; v.d_b = '0;
        v.ck_qa = 0; v.qa = '0; v.va = 0; v.ck_qb = 0; v.qb = '0; v.vb = 0;
        v.wa = 0; v.wb = 0; v.col = 0;
        return v;
    endfunction

    function automatic vec_t v_acc(input vec_t b, input logic port, input logic w, input logic ld,
                                   input logic ic, input int ad, input int d);
        vec_t v = b;
        if (port == 1'b0) begin
            v.ce_a = 1; v.wr_a = w; v.ld_a = ld; v.inc_a = ic;
            v.ad_a = ADDR_W'(ad); v.d_a = DATA_W'(d);
        end else begin
            v.ce_b = 1; v.wr_b = w; v.ld_b = ld; v.inc_b = ic;
            v.ad_b = ADDR_W'(ad); v.d_b = DATA_W'(d);
        end
        return v;
    endfunction

    function automatic vec_t v_exp(input vec_t b, input int qa, input logic va, input int qb,
                                   input logic vb, input logic wa, input logic wb, input logic col);
        vec_t v = b;
        v.ck_qa = 1; v.qa = DATA_W'(qa); v.va = va;
        v.ck_qb = 1; v.qb = DATA_W'(qb); v.vb = vb;
        v.wa = wa; v.wb = wb; v.col = col;
        return v;
    endfunction

    // Drive one edge's stimulus and queue what that edge must produce.
    task automatic apply(input vec_t v, input string tag);
        int e;
        data_exp_t de;
        flag_exp_t fe;
        @(negedge clk);
        rst = v.rst;
        ce_a = v.ce_a; wr_a = v.wr_a; ld_a = v.ld_a; inc_a = v.inc_a; addr_a = v.ad_a; din_a = v.d_a;
        ce_b = v.ce_b; wr_b = v.wr_b; ld_b = v.ld_b; inc_b = v.inc_b; addr_b = v.ad_b; din_b = v.d_b;
        e = edge_cnt + 1;
        fe.due = e; fe.tag = tag; fe.wa = v.wa; fe.wb = v.wb; fe.col = v.col;
        fq.push_back(fe);
        de.tag = tag; de.ck_qa = v.ck_qa; de.qa = v.qa; de.va = v.va;
        de.ck_qb = v.ck_qb; de.qb = v.qb; de.vb = v.vb;
        if (v.rst) begin
            // Reset flushes every output stage, so in-flight results never appear.
            while (dq.size() > 0 && dq[$].due >= e) void'(dq.pop_back());
            for (int k = 0; k < LAT; k++) begin
                de.due = e + k;
                dq.push_back(de);
            end
        end else begin
            de.due = e + LAT - 1;
            dq.push_back(de);
        end
    endtask

    initial begin : monitor
        data_exp_t de;
        flag_exp_t fe;
        forever begin
            @(posedge clk);
            edge_cnt = edge_cnt + 1;
            #1;
            if (fq.size() > 0 && fq[0].due == edge_cnt) begin
                fe = fq.pop_front();
                chk({fe.tag, " WrapA"}, 32'(wrap_a), 32'(fe.wa));
                chk({fe.tag, " WrapB"}, 32'(wrap_b), 32'(fe.wb));
                chk({fe.tag, " Collision"}, 32'(collision), 32'(fe.col));
            end
            if (dq.size() > 0 && dq[0].due == edge_cnt) begin
                de = dq.pop_front();
                if (de.ck_qa) chk({de.tag, " QA"}, 32'(q_a), 32'(de.qa));
                if (de.ck_qb) chk({de.tag, " QB"}, 32'(q_b), 32'(de.qb));
                chk({de.tag, " ValidA"}, 32'(valid_a), 32'(de.va));
                chk({de.tag, " ValidB"}, 32'(valid_b), 32'(de.vb));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        vec_t v;
        vec_t r;

        // ---------------- vector table ----------------
        v = v_idle(); v.rst = 1;
        vecs.push_back(v_exp(v, 0, 0, 0, 0, 0, 0, 0));
        // Port A streams 0..15 into 0..15; QB holds its reset value.
        for (int i = 0; i < 16; i++)
            vecs.push_back(v_exp(v_acc(v_idle(), 0, 1, i == 0, 1, 0, i), i, 0, 0, 0, 0, 0, 0));
        // Port B streams them back, QA holds the last write-through.
        for (int i = 0; i < 16; i++)
            vecs.push_back(v_exp(v_acc(v_idle(), 1, 0, i == 0, 1, 0, 0), 15, 0, i, 1, 0, 0, 0));
        // Wrap on port A: 2046, 2047, 0; then ptrA must sit at 1.
        vecs.push_back(v_exp(v_acc(v_idle(), 0, 1, 1, 1, 2046, 'hE0), 'hE0, 0, 15, 0, 0, 0, 0));
        vecs.push_back(v_exp(v_acc(v_idle(), 0, 1, 0, 1, 0, 'hE1), 'hE1, 0, 15, 0, 1, 0, 0));
        vecs.push_back(v_exp(v_acc(v_idle(), 0, 1, 0, 1, 0, 'hE2), 'hE2, 0, 15, 0, 0, 0, 0));
        vecs.push_back(v_exp(v_acc(v_acc(v_idle(), 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0),
                             'h01, 1, 'hE2, 1, 0, 0, 0));
        vecs.push_back(v_exp(v_acc(v_idle(), 1, 0, 1, 0, 2047, 0), 'h01, 0, 'hE1, 1, 0, 0, 0));
        // Both write address 5: A wins in the RAM, each Q shows its own data.
        vecs.push_back(v_exp(v_acc(v_acc(v_idle(), 0, 1, 1, 0, 5, 'hAA), 1, 1, 1, 0, 5, 'h55),
                             'hAA, 0, 'h55, 0, 0, 0, 1));
        vecs.push_back(v_exp(v_acc(v_idle(), 1, 0, 1, 0, 5, 0), 'hAA, 0, 'hAA, 1, 0, 0, 0));
        // A writes 9 while B is disabled but addressing 9: no collision.
        r = v_acc(v_idle(), 0, 1, 1, 0, 9, 'h11); r.ld_b = 1; r.ad_b = 9;
        vecs.push_back(v_exp(r, 'h11, 0, 'hAA, 0, 0, 0, 0));
        vecs.push_back(v_exp(v_acc(v_acc(v_idle(), 0, 1, 1, 0, 9, 'h22), 1, 0, 1, 0, 9, 0),
                             'h22, 0, 'h11, 1, 0, 0, 1));
        vecs.push_back(v_exp(v_acc(v_idle(), 1, 0, 1, 0, 9, 0), 'h22, 0, 'h22, 1, 0, 0, 0));
        vecs.push_back(v_exp(v_acc(v_acc(v_idle(), 0, 0, 1, 0, 9, 0), 1, 0, 1, 0, 9, 0),
                             'h22, 1, 'h22, 1, 0, 0, 0));
        // B writes 7 while A reads 7: A sees the old word.
        vecs.push_back(v_exp(v_acc(v_acc(v_idle(), 0, 0, 1, 0, 7, 0), 1, 1, 1, 0, 7, 'h77),
                             'h07, 1, 'h77, 0, 0, 0, 1));
        vecs.push_back(v_exp(v_acc(v_idle(), 0, 0, 1, 0, 7, 0), 'h77, 1, 'h77, 0, 0, 0, 0));
        // Port B pointer wrap, then a pointer read from address 0.
        vecs.push_back(v_exp(v_acc(v_idle(), 1, 0, 1, 1, 2047, 0), 'h77, 0, 'hE1, 1, 0, 1, 0));
        vecs.push_back(v_exp(v_acc(v_idle(), 1, 0, 0, 0, 0, 0), 'h77, 0, 'hE2, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // ---------------- reset in the middle of a burst ----------------
        apply(v_exp(v_acc(v_idle(), 0, 1, 1, 0, 22, 'h5A), 'h5A, 0, 'hE2, 0, 0, 0, 0), "rst_pre");
        apply(v_exp(v_acc(v_acc(v_idle(), 0, 1, 1, 1, 20, 'hC0), 1, 0, 1, 1, 9, 0),
                    'hC0, 0, 'h22, 1, 0, 0, 0), "rst_burst0");
        apply(v_exp(v_acc(v_acc(v_idle(), 0, 1, 0, 1, 0, 'hC1), 1, 0, 0, 1, 0, 0),
                    'hC1, 0, 'h0A, 1, 0, 0, 0), "rst_burst1");
        r = v_acc(v_acc(v_idle(), 0, 1, 0, 1, 0, 'hFF), 1, 0, 0, 1, 0, 0);
        r.rst = 1;
        apply(v_exp(r, 0, 0, 0, 0, 0, 0, 0), "rst_hit");
        apply(v_exp(v_acc(v_acc(v_idle(), 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0),
                    'hE2, 1, 'hE2, 1, 0, 0, 0), "rst_ptr0");
        apply(v_exp(v_acc(v_acc(v_idle(), 0, 0, 1, 0, 22, 0), 1, 0, 1, 0, 21, 0),
                    'h5A, 1, 'hC1, 1, 0, 0, 0), "rst_dropped");

        // Drain the scoreboard with idle cycles.
        @(negedge clk);
        rst = 0; ce_a = 0; ce_b = 0;
        repeat (LAT + 2) @(negedge clk);
        if (dq.size() != 0 || fq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d data and %0d flag results never compared", dq.size(), fq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
